// File: rtl/debounce_bank_if.sv
// Signal bundle between board-facing inputs and the debounce bank outputs.
// The master side drives raw inputs and repeat enable; the slave (bank) drives levels and pulses.
interface debounce_bank_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] i_in;
  logic            i_repeat_en;
  logic [N_CH-1:0] o_state;
  logic [N_CH-1:0] o_press;
  logic [N_CH-1:0] o_release;
  logic [N_CH-1:0] o_long_press;
  logic [N_CH-1:0] o_repeat;

  modport master (
    output i_in,
    output i_repeat_en,
    input  o_state,
    input  o_press,
    input  o_release,
    input  o_long_press,
    input  o_repeat
  );

  modport slave (
    input  i_in,
    input  i_repeat_en,
    output o_state,
    output o_press,
    output o_release,
    output o_long_press,
    output o_repeat
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel button debouncer on a shared 1 ms timebase, producing stable levels
// plus one-cycle press / release / long-press / auto-repeat pulses per channel.
module debounce_bank #(
  parameter int              CLK_HZ      = 100_000_000,
  parameter int              N_CH        = 4,
  parameter int              DEBOUNCE_MS = 20,
  parameter int              LONG_MS     = 1000,
  parameter int              REPEAT_MS   = 200,
  parameter logic [N_CH-1:0] ACTIVE_LOW  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  debounce_bank_if.slave  bus
);

  localparam int T  = CLK_HZ / 1000;
  localparam int PW = (T > 1) ? $clog2(T) : 1;
  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam int HW = $clog2(LONG_MS + 1);
  localparam int RW = $clog2(REPEAT_MS + 1);

  localparam logic [PW-1:0] PRE_LAST  = PW'(T - 1);
  localparam logic [DW-1:0] D_MAX     = DW'(DEBOUNCE_MS);
  localparam logic [HW-1:0] H_MAX     = HW'(LONG_MS);
  localparam logic [HW-1:0] H_LAST    = HW'(LONG_MS - 1);
  localparam logic [RW-1:0] R_LAST    = RW'(REPEAT_MS - 1);

  logic [PW-1:0]   r_pre;
  logic            w_tick;

  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;
  logic [N_CH-1:0] r_prev;
  logic [DW-1:0]   r_dcnt [N_CH];
  logic [HW-1:0]   r_hcnt [N_CH];
  logic [RW-1:0]   r_rcnt [N_CH];

  logic [N_CH-1:0] r_state;
  logic [N_CH-1:0] r_press;
  logic [N_CH-1:0] r_release;
  logic [N_CH-1:0] r_long;
  logic [N_CH-1:0] r_rpt;

  logic [N_CH-1:0] w_accept;
  logic [N_CH-1:0] w_rise;
  logic [N_CH-1:0] w_fall;
  logic [N_CH-1:0] w_long;
  logic [N_CH-1:0] w_rstep;
  logic [N_CH-1:0] w_rclr;

  assign w_tick = (r_pre == PRE_LAST);

  always_comb begin
    w_accept = '0;
    w_rise   = '0;
    w_fall   = '0;
    w_long   = '0;
    w_rstep  = '0;
    w_rclr   = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_accept[i] = (r_dcnt[i] == D_MAX) && (r_prev[i] != r_state[i]);
      w_rise[i]   = w_accept[i] &&  r_prev[i];
      w_fall[i]   = w_accept[i] && !r_prev[i];
      // A press being released on this edge must not also report a long press.
      w_long[i]   = r_state[i] && !w_fall[i] && w_tick && (r_hcnt[i] == H_LAST);
      w_rstep[i]  = r_state[i] && (r_hcnt[i] == H_MAX) && bus.i_repeat_en && w_tick;
      w_rclr[i]   = w_long[i] || w_fall[i] || !r_state[i] || !bus.i_repeat_en;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre     <= '0;
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_state   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_long    <= '0;
      r_rpt     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_dcnt[i] <= '0;
        r_hcnt[i] <= '0;
        r_rcnt[i] <= '0;
      end
    end else begin
      r_pre   <= w_tick ? '0 : r_pre + 1'b1;
      r_sync1 <= bus.i_in ^ ACTIVE_LOW;
      r_sync2 <= r_sync1;

      for (int i = 0; i < N_CH; i++) begin
        // Any input change restarts the stable-time measurement, even on a tick.
        if (r_sync2[i] != r_prev[i]) begin
          r_prev[i] <= r_sync2[i];
          r_dcnt[i] <= '0;
        end else if (w_tick && (r_dcnt[i] < D_MAX)) begin
          r_dcnt[i] <= r_dcnt[i] + 1'b1;
        end

        if (w_accept[i]) begin
          r_state[i] <= r_prev[i];
        end
        r_press[i]   <= w_rise[i];
        r_release[i] <= w_fall[i];

        if (w_fall[i] || !r_state[i]) begin
          r_hcnt[i] <= '0;
        end else if (w_tick && (r_hcnt[i] < H_MAX)) begin
          r_hcnt[i] <= r_hcnt[i] + 1'b1;
        end
        r_long[i] <= w_long[i];

        r_rpt[i] <= 1'b0;
        if (w_rclr[i]) begin
          r_rcnt[i] <= '0;
        end else if (w_rstep[i]) begin
          if (r_rcnt[i] == R_LAST) begin
            r_rcnt[i] <= '0;
            r_rpt[i]  <= 1'b1;
          end else begin
            r_rcnt[i] <= r_rcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.o_state      = r_state;
  assign bus.o_press      = r_press;
  assign bus.o_release    = r_release;
  assign bus.o_long_press = r_long;
  assign bus.o_repeat     = r_rpt;

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: every output pulse is matched against a queue of
// expected (channel, kind, cycle window) entries pushed when the stimulus is applied.
module tb_debounce_bank;

  localparam int N = 4;
  localparam int T = 10;
  localparam int D = 3;
  localparam int L = 10;
  localparam int R = 4;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_RPT   = 3;

  typedef struct {
    int ch;
    int kind;
    int lo;
    int hi;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_cyc [N][4];
  exp_t sb [$];
  exp_t m_e;
  string kname [4] = '{"press", "release", "long_press", "repeat"};
  logic [4*N-1:0] w_pulses;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debounce_bank_if #(.N_CH(N)) bus ();

  debounce_bank #(
    .CLK_HZ      (10_000),
    .N_CH        (N),
    .DEBOUNCE_MS (D),
    .LONG_MS     (L),
    .REPEAT_MS   (R),
    .ACTIVE_LOW  (4'b1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign w_pulses = {bus.o_repeat, bus.o_long_press, bus.o_release, bus.o_press};

  // Pulse monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < N; c++) begin
          if (w_pulses[k*N + c]) begin
            n_checks++;
            assert (sb.size() != 0) else begin
              n_fail++;
              $error("FAIL sb_unexpected: observed %s ch=%0d at cycle %0d, required no pulse", kname[k], c, cyc);
            end
            if (sb.size() != 0) begin
              m_e = sb.pop_front();
              n_checks++;
              assert (m_e.ch == c && m_e.kind == k && cyc >= m_e.lo && cyc <= m_e.hi) else begin
                n_fail++;
                $error("FAIL sb_match: observed %s ch=%0d at cycle %0d, required %s ch=%0d in [%0d,%0d]",
                       kname[k], c, cyc, kname[m_e.kind], m_e.ch, m_e.lo, m_e.hi);
              end
            end
            last_cyc[c][k] = cyc;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int c, input int k, input int lo, input int hi);
    exp_t x;
    x.ch = c; x.kind = k; x.lo = lo; x.hi = hi;
    sb.push_back(x);
  endtask

  task automatic wait_sb(input int budget, input string tag);
    int b;
    b = 0;
    while (sb.size() != 0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed %0d pending events, required 0", tag, sb.size());
    end
    sb.delete();
  endtask

  task automatic check_state(input logic [N-1:0] exp, input string tag);
    n_checks++;
    assert (bus.o_state === exp) else begin
      n_fail++;
      $error("FAIL %s: state observed %b required %b", tag, bus.o_state, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [5*N-1:0] obs;
    obs = {bus.o_state, w_pulses};
    n_checks++;
    assert (obs === '0) else begin
      n_fail++;
      $error("FAIL %s: outputs observed %h required 0", tag, obs);
    end
  endtask

  task automatic check_same(input int a, input int b, input string tag);
    n_checks++;
    assert (a == b) else begin
      n_fail++;
      $error("FAIL %s: observed cycle %0d vs %0d, required equal", tag, a, b);
    end
  endtask

  initial begin
    int t0;
    int p;
    int l;
    int r1;

    bus.i_in = 4'b1000;
    bus.i_repeat_en = 1'b1;
    rst_n = 1'b0;
    cycles(3);
    check_zero("reset");
    rst_n = 1'b1;
    cycles(80);
    check_state(4'b0000, "idle_after_reset");

    // Clean press and release on ch0
    bus.i_in[0] = 1'b1; t0 = cyc + 1;
    expect_ev(0, K_PRESS, t0 + 24, t0 + 33);
    wait_sb(60, "ch0_press");
    check_state(4'b0001, "ch0_pressed");
    cycles(5);
    bus.i_in[0] = 1'b0; t0 = cyc + 1;
    expect_ev(0, K_REL, t0 + 24, t0 + 33);
    wait_sb(60, "ch0_release");
    check_state(4'b0000, "ch0_released");

    // Bouncing ch1: 15-cycle toggles never reach the stable time
    for (int j = 0; j < 20; j++) begin
      bus.i_in[1] = ~bus.i_in[1];
      cycles(15);
      check_state(4'b0000, "ch1_bounce");
    end
    bus.i_in[1] = 1'b1; t0 = cyc + 1;
    expect_ev(1, K_PRESS, t0 + 24, t0 + 33);
    wait_sb(60, "ch1_press");
    check_state(4'b0010, "ch1_pressed");
    bus.i_in[1] = 1'b0; t0 = cyc + 1;
    expect_ev(1, K_REL, t0 + 24, t0 + 33);
    wait_sb(60, "ch1_release");

    // Simultaneous ch0 + ch1
    cycles(7);
    bus.i_in[1:0] = 2'b11; t0 = cyc + 1;
    expect_ev(0, K_PRESS, t0 + 24, t0 + 33);
    expect_ev(1, K_PRESS, t0 + 24, t0 + 33);
    wait_sb(60, "simul_press");
    check_same(last_cyc[0][K_PRESS], last_cyc[1][K_PRESS], "simul_press_same_cycle");
    check_state(4'b0011, "simul_pressed");
    bus.i_in[1:0] = 2'b00; t0 = cyc + 1;
    expect_ev(0, K_REL, t0 + 24, t0 + 33);
    expect_ev(1, K_REL, t0 + 24, t0 + 33);
    wait_sb(60, "simul_release");
    check_same(last_cyc[0][K_REL], last_cyc[1][K_REL], "simul_release_same_cycle");

    // ch2 long press with repeat enabled, then release stops repeats
    bus.i_in[2] = 1'b1; t0 = cyc + 1;
    expect_ev(2, K_PRESS, t0 + 24, t0 + 33);
    wait_sb(60, "ch2_press");
    p = last_cyc[2][K_PRESS];
    expect_ev(2, K_LONG, p + 91, p + 100);
    wait_sb(120, "ch2_long");
    l = last_cyc[2][K_LONG];
    expect_ev(2, K_RPT, l + 40, l + 40);
    expect_ev(2, K_RPT, l + 80, l + 80);
    expect_ev(2, K_RPT, l + 120, l + 120);
    wait_sb(140, "ch2_repeat");
    bus.i_in[2] = 1'b0; t0 = cyc + 1;
    expect_ev(2, K_REL, t0 + 24, t0 + 33);
    wait_sb(60, "ch2_release");
    cycles(80);
    check_state(4'b0000, "ch2_quiet_after_release");

    // ch2 long press with repeat disabled, then enabled mid-hold
    bus.i_repeat_en = 1'b0;
    bus.i_in[2] = 1'b1; t0 = cyc + 1;
    expect_ev(2, K_PRESS, t0 + 24, t0 + 33);
    wait_sb(60, "ch2n_press");
    p = last_cyc[2][K_PRESS];
    expect_ev(2, K_LONG, p + 91, p + 100);
    wait_sb(120, "ch2n_long");
    cycles(150);
    check_state(4'b0100, "ch2n_held_no_repeat");
    bus.i_repeat_en = 1'b1; t0 = cyc;
    expect_ev(2, K_RPT, t0 + 1 + (R - 1) * T, t0 + R * T);
    wait_sb(60, "ch2n_en_repeat");
    r1 = last_cyc[2][K_RPT];
    expect_ev(2, K_RPT, r1 + 40, r1 + 40);
    wait_sb(60, "ch2n_repeat2");
    bus.i_in[2] = 1'b0; t0 = cyc + 1;
    expect_ev(2, K_REL, t0 + 24, t0 + 33);
    wait_sb(60, "ch2n_release");

    // Active-low ch3
    bus.i_in[3] = 1'b0; t0 = cyc + 1;
    expect_ev(3, K_PRESS, t0 + 24, t0 + 33);
    wait_sb(60, "ch3_press");
    check_state(4'b1000, "ch3_pressed");
    bus.i_in[3] = 1'b1; t0 = cyc + 1;
    expect_ev(3, K_REL, t0 + 24, t0 + 33);
    wait_sb(60, "ch3_release");

    // Reset in the middle of a ch2 repeat sequence
    bus.i_in[2] = 1'b1; t0 = cyc + 1;
    expect_ev(2, K_PRESS, t0 + 24, t0 + 33);
    wait_sb(60, "rst_press");
    p = last_cyc[2][K_PRESS];
    expect_ev(2, K_LONG, p + 91, p + 100);
    wait_sb(120, "rst_long");
    l = last_cyc[2][K_LONG];
    expect_ev(2, K_RPT, l + 40, l + 40);
    wait_sb(60, "rst_repeat");
    cycles(10);
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_hold");
    cycles(3);
    check_zero("reset_mid_hold_held");
    rst_n = 1'b1; t0 = cyc + 1;
    expect_ev(2, K_PRESS, t0 + 24, t0 + 33);
    wait_sb(60, "rst_repress");
    check_state(4'b0100, "rst_repressed");
    bus.i_in[2] = 1'b0; t0 = cyc + 1;
    expect_ev(2, K_REL, t0 + 24, t0 + 33);
    wait_sb(60, "rst_release");
    cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
